// File: rtl/pingpong_buf_ctrl_pkg.sv
// Shared definitions for the ping-pong buffer controller.
//   bank_state_t : per-bank occupancy (EMPTY=0, FULL=1)
//   DEF_*        : default address width, data width and bank depth
package pingpong_buf_ctrl_pkg;

    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_state_t;

    localparam int DEF_AWIDTH    = 11;
    localparam int DEF_DWIDTH    = 40;
    localparam int DEF_NUM_WORDS = 2048;

endpackage

// File: rtl/pp_out_fifo2.sv
// Two-entry output FIFO with flow-through when empty.
//   clk, reset          : clock, synchronous active-high reset
//   push, push_data     : word arriving from the bank read port
//   pop                 : head consumed this cycle (only when head_valid)
//   head_valid/head_data: current head; an incoming word is visible the
//                         same cycle it arrives if the FIFO is empty
//   count               : stored entries, used by the read side as credits
module pp_out_fifo2 #(
    parameter int W = 41
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         head_valid,
    output logic [W-1:0] head_data,
    output logic [1:0]   count
);

    logic [W-1:0] ent0, ent1;
    logic         empty, store, deq;

    assign empty      = (count == 2'd0);
    assign head_valid = !empty || push;
    // Drive zero when nothing is presented so out_data is clean at reset.
    assign head_data  = !empty ? ent0 : (push ? push_data : '0);
    assign deq        = pop && !empty;
    // A word that arrives into an empty FIFO and is popped at once never lands.
    assign store      = push && !(empty && pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 2'd0;
            ent0  <= '0;
            ent1  <= '0;
        end else begin
            case ({deq, store})
                2'b11: begin
                    if (count == 2'd1) begin
                        ent0 <= push_data;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= push_data;
                    end
                end
                2'b10: begin
                    ent0  <= ent1;
                    count <= count - 2'd1;
                end
                2'b01: begin
                    if (empty) ent0 <= push_data;
                    else       ent1 <= push_data;
                    count <= count + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pingpong_buf_ctrl.sv
// Ping-pong buffer controller for a two-bank BRAM.
//   in_*        : framed valid/ready input stream (in_last closes a frame)
//   out_*       : valid/ready drained stream with frame-end flag
//   mem_wr_*    : write port, one-hot bank enable, same-cycle as accept
//   mem_rd_*    : read issue port; mem_rd_data0/1 return one cycle later
//   bank_full   : per-bank FULL status
// One bank fills while the other drains; a frame is force-closed at
// NUM_WORDS words.
module pingpong_buf_ctrl
    import pingpong_buf_ctrl_pkg::*;
#(
    parameter int AWIDTH    = DEF_AWIDTH,
    parameter int NUM_WORDS = DEF_NUM_WORDS,
    parameter int DWIDTH    = DEF_DWIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_last,
    output logic [1:0]        mem_wr_en,
    output logic [AWIDTH-1:0] mem_wr_addr,
    output logic [DWIDTH-1:0] mem_wr_data,
    output logic              mem_rd_en,
    output logic              mem_rd_bank,
    output logic [AWIDTH-1:0] mem_rd_addr,
    input  logic [DWIDTH-1:0] mem_rd_data0,
    input  logic [DWIDTH-1:0] mem_rd_data1,
    output logic [1:0]        bank_full
);

    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(NUM_WORDS - 1);

    bank_state_t       bank_st [2];
    bank_state_t       bank_st_nxt [2];
    logic [AWIDTH:0]   bank_len [2];
    logic [AWIDTH:0]   bank_len_nxt [2];
    logic              wbank, wbank_nxt, rbank, rbank_nxt;
    logic [AWIDTH-1:0] wcnt, wcnt_nxt, rcnt, rcnt_nxt;

    logic              rd_inflight, rd_inflight_bank, rd_inflight_last;
    logic              wr_fire, wr_close, rd_issue, rd_last;
    logic [1:0]        fifo_count;
    logic [DWIDTH:0]   fifo_head;

    assign in_ready    = (bank_st[wbank] == BANK_EMPTY);
    assign wr_fire     = in_valid && in_ready;
    assign wr_close    = in_last || (wcnt == LAST_ADDR);
    assign mem_wr_en   = wr_fire ? (wbank ? 2'b10 : 2'b01) : 2'b00;
    assign mem_wr_addr = wcnt;
    assign mem_wr_data = in_data;

    // Credits: stored words plus the read still in the BRAM pipeline may
    // never exceed the FIFO depth.
    assign rd_issue    = (bank_st[rbank] == BANK_FULL) &&
                         ((fifo_count + {1'b0, rd_inflight}) < 2'd2);
    assign rd_last     = ({1'b0, rcnt} == bank_len[rbank] - (AWIDTH+1)'(1));
    assign mem_rd_en   = rd_issue;
    assign mem_rd_bank = rbank;
    assign mem_rd_addr = rcnt;

    assign bank_full   = {bank_st[1] == BANK_FULL, bank_st[0] == BANK_FULL};

    // Write and read sides never touch the same bank in one cycle: the
    // writer only closes an EMPTY bank, the reader only releases a FULL one.
    always_comb begin
        bank_st_nxt  = bank_st;
        bank_len_nxt = bank_len;
        wbank_nxt    = wbank;
        wcnt_nxt     = wcnt;
        rbank_nxt    = rbank;
        rcnt_nxt     = rcnt;
        if (wr_fire) begin
            if (wr_close) begin
                bank_st_nxt[wbank]  = BANK_FULL;
                bank_len_nxt[wbank] = {1'b0, wcnt} + (AWIDTH+1)'(1);
                wcnt_nxt            = '0;
                wbank_nxt           = ~wbank;
            end else begin
                wcnt_nxt = wcnt + AWIDTH'(1);
            end
        end
        if (rd_issue) begin
            if (rd_last) begin
                bank_st_nxt[rbank] = BANK_EMPTY;
                rcnt_nxt           = '0;
                rbank_nxt          = ~rbank;
            end else begin
                rcnt_nxt = rcnt + AWIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                bank_st[i]  <= BANK_EMPTY;
                bank_len[i] <= '0;
            end
            wbank            <= 1'b0;
            wcnt             <= '0;
            rbank            <= 1'b0;
            rcnt             <= '0;
            rd_inflight      <= 1'b0;
            rd_inflight_bank <= 1'b0;
            rd_inflight_last <= 1'b0;
        end else begin
            bank_st          <= bank_st_nxt;
            bank_len         <= bank_len_nxt;
            wbank            <= wbank_nxt;
            wcnt             <= wcnt_nxt;
            rbank            <= rbank_nxt;
            rcnt             <= rcnt_nxt;
            rd_inflight      <= rd_issue;
            rd_inflight_bank <= rbank;
            rd_inflight_last <= rd_last;
        end
    end

    pp_out_fifo2 #(.W(DWIDTH + 1)) u_out_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (rd_inflight),
        .push_data  ({rd_inflight_last,
                      rd_inflight_bank ? mem_rd_data1 : mem_rd_data0}),
        .pop        (out_valid && out_ready),
        .head_valid (out_valid),
        .head_data  (fifo_head),
        .count      (fifo_count)
    );

    assign out_last = fifo_head[DWIDTH];
    assign out_data = fifo_head[DWIDTH-1:0];

endmodule

// File: tb/tb_pingpong_buf_ctrl.sv
// Directed bench for pingpong_buf_ctrl with a behavioural two-bank BRAM.
module tb_pingpong_buf_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_last;
    logic [39:0] in_data;
    logic        out_valid, out_ready, out_last;
    logic [39:0] out_data;
    logic [1:0]  mem_wr_en;
    logic [10:0] mem_wr_addr, mem_rd_addr;
    logic [39:0] mem_wr_data, rd0, rd1;
    logic        mem_rd_en, mem_rd_bank;
    logic [1:0]  bank_full;

    typedef struct { logic [1:0] en; logic [10:0] a; logic [39:0] d; int t; } wr_t;
    typedef struct { logic l; logic [39:0] d; int t; } ob_t;
    typedef struct { logic b; logic [10:0] a; int t; } rd_t;

    wr_t wlog[$];
    ob_t olog[$];
    rd_t rlog[$];

    logic [39:0] mem0 [2048];
    logic [39:0] mem1 [2048];
    int cycles = 0;
    int occ = 0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pingpong_buf_ctrl dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_en(mem_rd_en), .mem_rd_bank(mem_rd_bank), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data0(rd0), .mem_rd_data1(rd1), .bank_full(bank_full)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // BRAM model: registered read, one-cycle latency.
    always @(posedge clk) begin
        if (mem_wr_en[0]) mem0[mem_wr_addr] <= mem_wr_data;
        if (mem_wr_en[1]) mem1[mem_wr_addr] <= mem_wr_data;
        if (mem_rd_en) begin
            if (mem_rd_bank) rd1 <= mem1[mem_rd_addr];
            else             rd0 <= mem0[mem_rd_addr];
        end
    end

    // Logs every write, read issue and output pop; occ = issued - popped.
    always @(posedge clk) begin
        cycles <= cycles + 1;
        if (reset) begin
            occ <= 0;
        end else begin
            if (mem_rd_en) begin
                chk("rd_credit", 64'(occ < 2), 64'd1);
                rlog.push_back('{mem_rd_bank, mem_rd_addr, cycles});
            end
            if (mem_wr_en != 2'b00) wlog.push_back('{mem_wr_en, mem_wr_addr, mem_wr_data, cycles});
            if (out_valid && out_ready) olog.push_back('{out_last, out_data, cycles});
            occ <= occ + (mem_rd_en ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
        end
    end

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        wlog.delete(); olog.delete(); rlog.delete();
    endtask

    // Called at a negedge; returns at the negedge after the word is accepted.
    task automatic send(input logic [39:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1; in_data = d; in_last = l;
        #1;
        while (!in_ready && n < 200) begin @(negedge clk); #1; n++; end
        chk("in_accept_bound", 64'(n < 200), 64'd1);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_out(input int n);
        int k = 0;
        while (olog.size() < n && k < 5000) begin @(negedge clk); k++; end
        chk("drain_count", 64'(olog.size()), 64'(n));
    endtask

    initial begin
        int t_ready;
        int t_iss;
        logic [39:0] v;
        out_ready = 1'b1;
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        @(negedge clk); @(negedge clk);
        // reset values while reset is held
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_wr_en", 64'(mem_wr_en), 64'd0);
        chk("rst_rd_en", 64'(mem_rd_en), 64'd0);
        chk("rst_wr_addr", 64'(mem_wr_addr), 64'd0);
        chk("rst_rd_addr", 64'(mem_rd_addr), 64'd0);
        chk("rst_bank_full", 64'(bank_full), 64'd0);

        // 1: one 4-word frame
        do_reset();
        for (int i = 1; i <= 4; i++) send(40'(i), i == 4);
        wait_out(4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_wr_en", 64'(wlog[i].en), 64'd1);
            chk("t1_wr_addr", 64'(wlog[i].a), 64'(i));
            chk("t1_out_data", olog[i].d, 64'(i + 1));
            chk("t1_out_last", 64'(olog[i].l), 64'(i == 3));
        end
        chk("t1_latency", 64'(olog[0].t), 64'(wlog[3].t + 2));

        // 2: 3-word and 5-word frames with the sink stalled
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(40'h11 + 40'(i), i == 2);
        for (int i = 0; i < 5; i++) send(40'h21 + 40'(i), i == 4);
        #1;
        chk("t2_bank_full", 64'(bank_full), 64'h3);
        chk("t2_in_ready", 64'(in_ready), 64'd0);
        chk("t2_out_valid", 64'(out_valid), 64'd1);
        chk("t2_head", out_data, 64'h11);
        @(negedge clk);
        out_ready = 1'b1;
        t_ready = -1;
        for (int k = 0; k < 50 && t_ready < 0; k++) begin
            #1;
            if (in_ready) t_ready = cycles;
            else @(negedge clk);
        end
        t_iss = -1;
        foreach (rlog[i]) if (rlog[i].b == 1'b0 && rlog[i].a == 11'd2) t_iss = rlog[i].t;
        chk("t2_ready_return", 64'(t_ready), 64'(t_iss + 1));
        wait_out(8);
        for (int i = 0; i < 8; i++) begin
            v = (i < 3) ? 40'h11 + 40'(i) : 40'h21 + 40'(i - 3);
            chk("t2_out_data", olog[i].d, 64'(v));
            chk("t2_out_last", 64'(olog[i].l), 64'(i == 2 || i == 7));
        end

        // 3: 2048-word frame with no in_last, then a 1-word frame
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 2048; i++) send(40'(i), 1'b0);
        send(40'hBEEF, 1'b1);
        wait_out(2049);
        chk("t3_close_en", 64'(wlog[2047].en), 64'd1);
        chk("t3_close_addr", 64'(wlog[2047].a), 64'd2047);
        chk("t3_next_en", 64'(wlog[2048].en), 64'd2);
        chk("t3_next_addr", 64'(wlog[2048].a), 64'd0);
        for (int i = 0; i < 2049; i++) begin
            v = (i < 2048) ? 40'(i) : 40'hBEEF;
            chk("t3_out_data", olog[i].d, 64'(v));
            chk("t3_out_last", 64'(olog[i].l), 64'(i >= 2047));
        end

        // 4: 6-word drain with out_ready toggling
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(40'h31 + 40'(i), i == 5);
        for (int k = 0; k < 100 && olog.size() < 6; k++) begin
            out_ready = ~out_ready;
            @(negedge clk);
        end
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("t4_count", 64'(olog.size()), 64'd6);
        for (int i = 0; i < 6 && i < olog.size(); i++) begin
            chk("t4_out_data", olog[i].d, 64'h31 + 64'(i));
            chk("t4_out_last", 64'(olog[i].l), 64'(i == 5));
        end

        // 5: reset mid-frame
        do_reset();
        send(40'h41, 1'b0);
        send(40'h42, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wlog.delete(); olog.delete(); rlog.delete();
        #1;
        chk("t5_in_ready", 64'(in_ready), 64'd1);
        chk("t5_bank_full", 64'(bank_full), 64'd0);
        chk("t5_out_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        send(40'hAA, 1'b1);
        wait_out(1);
        repeat (5) @(negedge clk);
        chk("t5_wr_count", 64'(wlog.size()), 64'd1);
        chk("t5_wr_en", 64'(wlog[0].en), 64'd1);
        chk("t5_wr_addr", 64'(wlog[0].a), 64'd0);
        chk("t5_out_count", 64'(olog.size()), 64'd1);
        chk("t5_out_data", olog[0].d, 64'hAA);
        chk("t5_out_last", 64'(olog[0].l), 64'd1);

        // 6: continuous 1-word frames
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(40'h50 + 40'(i), 1'b1);
        wait_out(8);
        chk("t6_latency", 64'(olog[0].t), 64'(wlog[0].t + 2));
        for (int i = 0; i < 8; i++) begin
            chk("t6_wr_bank", 64'(wlog[i].en), (i % 2 == 1) ? 64'd2 : 64'd1);
            chk("t6_wr_addr", 64'(wlog[i].a), 64'd0);
            chk("t6_wr_time", 64'(wlog[i].t), 64'(wlog[0].t + i));
            chk("t6_out_data", olog[i].d, 64'h50 + 64'(i));
            chk("t6_out_last", 64'(olog[i].l), 64'd1);
            chk("t6_out_time", 64'(olog[i].t), 64'(olog[0].t + i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pingpong_buf_ctrl.md
Name: pingpong_buf_ctrl

Overview:
- Control stage that sits directly upstream of the team's two-bank 2048x40 ping-pong BRAM.
- Accepts a valid/ready stream of 40-bit words framed by a last flag and writes each frame into the current write bank.
- Hands full banks to the read side, which streams them back out with valid/ready backpressure.
- Makes fill and drain alternate across the two banks, so one bank fills while the other drains.

Parameters:
- AWIDTH, 11, bank address width
- NUM_WORDS, 2048, words per bank; a frame is force-closed at this length
- DWIDTH, 40, data word width

Ports:
- clk  in  1  clock
- reset  in  1  reset
- in_valid  in  1  upstream word valid
- in_ready  out  1  accept word this cycle
- in_data  in  DWIDTH  upstream word
- in_last  in  1  final word of frame
- out_valid  out  1  downstream word valid
- out_ready  in  1  downstream accepts
- out_data  out  DWIDTH  drained word
- out_last  out  1  final word of drained frame
- mem_wr_en  out  2  per-bank write enable, one-hot or zero
- mem_wr_addr  out  AWIDTH  write address
- mem_wr_data  out  DWIDTH  write data
- mem_rd_en  out  1  read issue strobe
- mem_rd_bank  out  1  bank being read
- mem_rd_addr  out  AWIDTH  read address
- mem_rd_data0  in  DWIDTH  bank 0 read data, registered, 1-cycle latency
- mem_rd_data1  in  DWIDTH  bank 1 read data, registered, 1-cycle latency
- bank_full  out  2  per-bank FULL status

Behaviour:
- Clock and reset (decided): clock clk; reset is synchronous, active-high.
- Reset values:
  - wbank=0, rbank=0, wcnt=0, rcnt=0.
  - Both banks EMPTY; len regs 0; output FIFO flushed; in-flight read discarded.
  - Outputs: in_ready=1, out_valid=0, out_last=0, out_data=0, mem_wr_en=0, mem_rd_en=0, mem_wr_addr=0, mem_rd_addr=0, bank_full=0.
- Bank state: each bank is EMPTY or FULL, and stores len (1..NUM_WORDS).
- Write side:
  - in_ready = (state[wbank]==EMPTY), combinational from registered state.
  - On in_valid&&in_ready: mem_wr_en[wbank]=1, mem_wr_addr=wcnt, mem_wr_data=in_data, all combinational in the same cycle.
  - If in_last or wcnt==NUM_WORDS-1: at the edge, state[wbank]<=FULL, len[wbank]<=wcnt+1, wcnt<=0, wbank<=~wbank.
  - Otherwise wcnt<=wcnt+1.
- Read side:
  - Output FIFO is 2 entries, {last,data}. A read issues when state[rbank]==FULL and (fifo_count + inflight) < 2.
  - On issue: mem_rd_en=1, mem_rd_bank=rbank, mem_rd_addr=rcnt.
  - Next cycle, data from the selected bank (mem_rd_data0 or mem_rd_data1 per the registered bank) is pushed with last=(rcnt_issued==len-1).
  - When the last address is issued: at that edge, state[rbank]<=EMPTY, rcnt<=0, rbank<=~rbank. Otherwise rcnt<=rcnt+1.
- Simultaneous release and refill are legal:
  - A bank released at edge E can be written from the cycle after E.
  - The final read was captured at E, so there is no hazard.
- Output: out_valid = FIFO non-empty; head pops on out_valid&&out_ready. Push and pop in the same cycle are allowed.
- Latency with an empty pipeline: a single-word frame accepted in cycle N gives out_valid in cycle N+2.
- Sustained throughput: 1 word/cycle in and out when out_ready=1.
- Both banks FULL: in_ready=0 until the read side releases a bank.
- Neither bank FULL: the read side idles; mem_rd_en=0.
- bank_full[i] = (state[i]==FULL).
- Reset mid-frame: the partial frame is dropped and all state returns to reset values; memory contents are don't-care.

Decomposition:
- Shared package holds:
  - Bank state encoding (EMPTY=0, FULL=1).
  - Default AWIDTH/DWIDTH/NUM_WORDS constants.
- Sub-module pp_out_fifo2: the 2-entry {last,data} FIFO with count output, reused for credit accounting.
- Write and read FSMs stay in the top module.

Test Plan:
- Reset, then one 4-word frame (data 0x01..0x04, last on 0x04), out_ready=1:
  - mem_wr_en=01 at addresses 0..3.
  - Output 0x01..0x04 with out_last only on 0x04.
  - First out_valid 2 cycles after the 0x04 accept.
- Frames of 3 and 5 words back-to-back with out_ready=0:
  - bank_full=11 and in_ready=0 after the 8th word.
  - Raising out_ready drains 3 then 5 words in order.
  - in_ready returns 1 on the cycle after bank 0's last read issues.
- 2048-word frame with no in_last:
  - Bank closes at wcnt=2047; len=2048.
  - Word 2049 goes to bank 1, address 0.
- out_ready toggling 1,0,1,0 during a 6-word drain:
  - No word is lost or duplicated.
  - mem_rd_en never issues with fifo_count+inflight=2.
- Reset asserted mid-frame after 2 of 5 words:
  - Next cycle: in_ready=1, bank_full=00, out_valid=0.
  - A new 1-word frame 0xAA is written to bank 0, address 0, and is output alone with out_last=1.
- Continuous 1-word frames with out_ready=1: one word out per cycle after the 2-cycle fill, banks alternating 0,1,0,1.
